// File: rtl/serial_adder_ctrl.sv
// ============================================================================
//  Module      : serial_adder_ctrl
//  Description : Bit-serial WIDTH-bit adder controller. Parallel-loads two
//                operands and feeds one bit pair per clock (LSB first) through
//                a local one-bit full-adder cell with a registered carry. Each
//                sum bit is shifted into a result register. A start/busy/done
//                handshake faces the requester. The final sum and carry are
//                published only when the operation completes.
//                Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' port that
//                selects subtraction (a - b mod 2^WIDTH).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter is one bit wider than strictly needed so it can never wrap
  // before reaching the last bit index.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic               w_fa_a;
  logic               w_fa_b;
  logic               w_fa_s;
  logic               w_fa_co;
  logic               w_load_carry;
  logic [WIDTH-1:0]   w_res_shifted;

`ifdef SERIAL_ADDER_SUB_EN
  logic               sub_q, sub_d;

  // Subtraction is a + ~b + 1: invert B at the cell and force the carry-in.
  assign w_fa_b       = b_q[0] ^ sub_q;
  assign w_load_carry = sub ? 1'b1 : cin;

  // Operation-select register, captured alongside the operands.
  always_ff @(posedge clk) begin
    if (rst) sub_q <= 1'b0;
    else     sub_q <= sub_d;
  end
`else
  assign w_fa_b       = b_q[0];
  assign w_load_carry = cin;
`endif

  // One-bit full-adder cell fed from the low bits of the operand shifters.
  assign w_fa_a        = a_q[0];
  assign w_fa_s        = w_fa_a ^ w_fa_b ^ carry_q;
  assign w_fa_co       = (w_fa_a & w_fa_b) | (carry_q & (w_fa_a ^ w_fa_b));
  assign w_res_shifted = {w_fa_s, res_q[WIDTH-1:1]};

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          a_d     = a;
          b_d     = b;
          carry_d = w_load_carry;
          cnt_d   = '0;
          res_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
          sub_d   = sub;
`endif
        end
      end
      S_SHIFT: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = w_fa_co;
        cnt_d   = cnt_q + C_CNT_ONE;
        res_d   = w_res_shifted;
        // Publish the complete result only on the final bit so no partial
        // value is ever visible on sum/cout.
        if (cnt_q == C_LAST_CNT) begin
          state_d = S_DONE;
          sum_d   = w_res_shifted;
          cout_d  = w_fa_co;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// ============================================================================
//  Module      : tb_serial_adder_ctrl
//  Description : Directed self-checking bench for serial_adder_ctrl (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation with start held for exactly the accept edge, then
  // check busy length, single done pulse and the result.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic tcin, input logic tsub,
                        input logic [7:0] exp_sum, input logic exp_cout);
    int busy_cnt;
    a     = ta;
    b     = tb_;
    cin   = tcin;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = tsub;
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      if (busy) busy_cnt++;
      step();
    end
    check({tag, "_busy_len"}, busy_cnt, 8);
    check({tag, "_done"}, {31'd0, done}, 1);
    check({tag, "_sum"}, {24'd0, sum}, {24'd0, exp_sum});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
    step();
    check({tag, "_done_pulse"}, {31'd0, done}, 0);
  endtask

  int done_cnt;
  int t_first;
  int t_second;
  logic [7:0] s_first, s_second;
  logic       c_first, c_second;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_sum",  {24'd0, sum}, 0);
    check("rst_cout", {31'd0, cout}, 0);

    run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
    run_op("add_7f_01_c", 8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 1'b0);
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);

    // Start while busy: second request on cycle 4 must be ignored.
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    step();                 // accept edge -> cycle 1
    start = 1'b0;
    step(); step();         // cycle 3
    check("busy_sum_held", {24'd0, sum}, 8'hFF);
    step();                 // cycle 4
    a = 8'h01; b = 8'h01; start = 1'b1;
    step();
    start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        done_cnt++;
        check("busy_ign_sum", {24'd0, sum}, 8'h30);
      end
      step();
    end
    check("busy_ign_done_cnt", done_cnt, 1);

    // Back-to-back with start held high; operands change after first accept.
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    step();
    a = 8'h80; b = 8'h80;
    done_cnt = 0; t_first = 0; t_second = 0;
    s_first = '0; s_second = '0; c_first = 1'b0; c_second = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          t_first = cyc; s_first = sum; c_first = cout;
        end else if (done_cnt == 2) begin
          t_second = cyc; s_second = sum; c_second = cout;
          start = 1'b0;
        end
      end
      step();
    end
    start = 1'b0;
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_spacing", t_second - t_first, 10);
    check("b2b_sum1", {24'd0, s_first}, 8'h03);
    check("b2b_cout1", {31'd0, c_first}, 0);
    check("b2b_sum2", {24'd0, s_second}, 8'h00);
    check("b2b_cout2", {31'd0, c_second}, 1);

    // Establish a nonzero held result before the reset test.
    run_op("pre_rst", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);

    // Reset mid-operation on cycle 5.
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    step();                 // cycle 1
    start = 1'b0;
    step(); step(); step(); step();   // cycle 5
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_done", {31'd0, done}, 0);
    check("mid_rst_sum",  {24'd0, sum}, 0);
    check("mid_rst_cout", {31'd0, cout}, 0);
    run_op("post_rst", 8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
    run_op("sub_01_02", 8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0);
    run_op("add_after_sub", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
